bcd_conv_arbiter: RTL
=====================

// Module: bcd_conv_arbiter
// PURPOSE
//  Shares one serial 24-bit binary-to-BCD converter among N_REQ requesters.
//  Round-robin arbitration; winning operand is registered and held stable for the
//  whole conversion. The block pulses the converter load, times the conversion,
//  captures the 8-digit BCD result and returns it with a one-cycle ack and the ID.
//  Sits between display/report clients and the shared converter instance.
// PARAMETERS
//  N_REQ     4    number of requesters (>=1); ID_W = max(1,$clog2(N_REQ))
//  BIN_W     24   operand width
//  BCD_W     32   result width (8 digits)
//  CONV_LAT  25   edges from converter sampling conv_load to result valid
// PORTS
//  clock      in   1            system clock, rising edge
//  a_rst_n    in   1            async active-low reset
//  req        in   N_REQ        request; held high with operand until ack
//  bin_in     in   N_REQ*BIN_W  operands; requester i at [i*BIN_W +: BIN_W]
//  ack        out  N_REQ        one-hot, 1-cycle pulse: result for requester i
//  bcd_out    out  BCD_W        captured result; holds until next completion
//  bcd_id     out  ID_W         requester index of bcd_out
//  busy       out  1            high from grant until return to IDLE
//  conv_load  out  1            to converter load, 1-cycle pulse
//  conv_bin   out  BIN_W        to converter bin, registered, stable all conversion
//  conv_bcd   in   BCD_W        from converter bcd
// BEHAVIOUR
//  - Reset: ack=0, bcd_out=0, bcd_id=0, busy=0, conv_load=0, conv_bin=0,
//    rr pointer=0, FSM=IDLE. Reset mid-conversion aborts; no ack. Converter
//    reset tied to ~a_rst_n at top level.
//  - FSM IDLE->LOAD->BUSY->DONE->IDLE, all outputs registered.
//  - IDLE: if |req, grant first requester at or after rr pointer (wrapping
//    N_REQ-1->0), latch conv_bin, grant ID, busy=1; ->LOAD. Else stay.
//  - LOAD: conv_load=1 for exactly this cycle; cnt=0; ->BUSY.
//  - BUSY: cnt++ each edge; on edge where cnt==CONV_LAT-1 (i.e. CONV_LAT-th
//    edge after converter sampled load): bcd_out<=conv_bcd, bcd_id<=ID,
//    ack[ID]<=1; ->DONE.
//  - DONE: ack deasserts; rr pointer<=ID+1 (wrap); busy<=0; ->IDLE.
//  - Latency: req seen at IDLE edge E0 -> ack high after E0+CONV_LAT+1.
//    Back-to-back grant interval: CONV_LAT+3 cycles; converter idle >=1 cycle
//    between result sample and next load.
//  - req changes during LOAD/BUSY ignored; arbitration only in IDLE.
//    Withdrawing req after grant is a protocol violation: conversion completes
//    and ack still pulses. New reqs arriving in DONE wait for IDLE.
//  - N_REQ=1: pointer stays 0; grant whenever req[0].
// CONFIGURATION
//  BCD_CONV_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
//    rr pointer not used/updated. Undefined (default): round-robin as above.
// TESTING
//  1. req[0], bin_in[0]=24'h002649 -> one conv_load pulse; ack[0] 26 cycles
//     after grant edge; bcd_out=32'h00009801, bcd_id=0.
//  2. req[2], bin=24'hFFFFFF -> bcd_out=32'h16777215, ack=4'b0100; bin=0 ->
//     bcd_out=0.
//  3. req=4'b1111 held, distinct operands -> acks in order 0,1,2,3,0; each
//     bcd_out matches its operand; grant spacing 28 cycles. With
//     BCD_CONV_ARB_FIXED_PRIO_EN: ack[0] every time, others starved.
//  4. Change bin_in[1] every cycle during BUSY after grant of 1 ->
//     conv_bin constant; result equals value at grant.
//  5. a_rst_n low at cnt=10 -> all outputs 0 asynchronously; no ack; after
//     release, pending req restarts from IDLE with full latency.
//  6. req[3] only, pointer at 0 -> grant 3 immediately (wrap search); next
//     pointer 0.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// Shares one serial binary-to-BCD converter among N_REQ requesters with round-robin grant.
// Define BCD_CONV_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module bcd_conv_arbiter #(
   parameter int N_REQ    = 4,
   parameter int BIN_W    = 24,
   parameter int BCD_W    = 32,
   parameter int CONV_LAT = 25,
   parameter int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clock,
   input  logic                   a_rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*BIN_W-1:0] bin_in,
   output logic [N_REQ-1:0]       ack,
   output logic [BCD_W-1:0]       bcd_out,
   output logic [ID_W-1:0]        bcd_id,
   output logic                   busy,
   output logic                   conv_load,
   output logic [BIN_W-1:0]       conv_bin,
   input  logic [BCD_W-1:0]       conv_bcd
);
   localparam int CNT_W = $clog2(CONV_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_BUSY = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [BIN_W-1:0]   conv_bin_q, conv_bin_d;
   logic               conv_load_q, conv_load_d;
   logic               busy_q, busy_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
   logic [ID_W-1:0]    bcd_id_q, bcd_id_d;
   logic [ID_W-1:0]    gnt_s;
   logic [BIN_W-1:0]   sel_bin_s;
`ifdef BCD_CONV_ARB_FIXED_PRIO_EN
`else
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
`endif

   // First requester at or after ptr, wrapping past N_REQ-1 back to 0.
   function automatic logic [ID_W-1:0] pick(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] ptr);
      logic [ID_W-1:0] w;
      logic [ID_W-1:0] idx;
      logic            found;
      w     = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx   = ID_W'((int'(ptr) + k) % N_REQ);
         w     = (!found && r[idx]) ? idx : w;
         found = found | r[idx];
      end
      return w;
   endfunction

   // Arbitration and operand selection
   always_comb begin
`ifdef BCD_CONV_ARB_FIXED_PRIO_EN
      gnt_s = pick(req, '0);
`else
      gnt_s = pick(req, rr_ptr_q);
`endif
      sel_bin_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_bin_s = (gnt_s == ID_W'(i)) ? bin_in[i*BIN_W +: BIN_W] : sel_bin_s;
      end
   end

   // FSM state register
   always_ff @(posedge clock or negedge a_rst_n) begin
      if (!a_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (|req) state_d = S_LOAD;
            else      state_d = S_IDLE;
         end
         S_LOAD: state_d = S_BUSY;
         S_BUSY: begin
            if (cnt_q == CNT_LAST) state_d = S_DONE;
            else                   state_d = S_BUSY;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM output and datapath next values; every output is a flop so load/ack are glitch-free
   always_comb begin
      cnt_d       = cnt_q;
      id_d        = id_q;
      conv_bin_d  = conv_bin_q;
      conv_load_d = 1'b0;
      busy_d      = busy_q;
      ack_d       = '0;
      bcd_out_d   = bcd_out_q;
      bcd_id_d    = bcd_id_q;
`ifdef BCD_CONV_ARB_FIXED_PRIO_EN
`else
      rr_ptr_d    = rr_ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               id_d        = gnt_s;
               conv_bin_d  = sel_bin_s;
               conv_load_d = 1'b1;
               busy_d      = 1'b1;
            end else begin
               busy_d      = 1'b0;
            end
         end
         S_LOAD: cnt_d = '0;
         S_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               bcd_out_d = conv_bcd;
               bcd_id_d  = id_q;
               ack_d     = N_REQ'(1'b1) << id_q;
            end else begin
               ack_d     = '0;
            end
         end
         S_DONE: begin
            busy_d = 1'b0;
`ifdef BCD_CONV_ARB_FIXED_PRIO_EN
`else
            rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : (id_q + ID_W'(1));
`endif
         end
         default: busy_d = 1'b0;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clock or negedge a_rst_n) begin
      if (!a_rst_n) begin
         cnt_q       <= '0;
         id_q        <= '0;
         conv_bin_q  <= '0;
         conv_load_q <= 1'b0;
         busy_q      <= 1'b0;
         ack_q       <= '0;
         bcd_out_q   <= '0;
         bcd_id_q    <= '0;
`ifdef BCD_CONV_ARB_FIXED_PRIO_EN
`else
         rr_ptr_q    <= '0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         id_q        <= id_d;
         conv_bin_q  <= conv_bin_d;
         conv_load_q <= conv_load_d;
         busy_q      <= busy_d;
         ack_q       <= ack_d;
         bcd_out_q   <= bcd_out_d;
         bcd_id_q    <= bcd_id_d;
`ifdef BCD_CONV_ARB_FIXED_PRIO_EN
`else
         rr_ptr_q    <= rr_ptr_d;
`endif
      end
   end

   assign ack       = ack_q;
   assign bcd_out   = bcd_out_q;
   assign bcd_id    = bcd_id_q;
   assign busy      = busy_q;
   assign conv_load = conv_load_q;
   assign conv_bin  = conv_bin_q;

endmodule
